// File: rtl/tag_lookup_reader.sv
// tag_lookup_reader: read-side controller for a way-halting cache tag store.
// A request is captured in IDLE. In FILTER the narrow main tags are
// pre-compared and non-matching ways are halted. In COMPARE only the
// surviving ways have their halt-tag read enabled and compared. RESP holds
// the result until the consumer accepts it.
// Optional build macro: TAG_LOOKUP_STATS_EN adds saturating 16-bit counters
// stat_lookups, stat_hits and stat_halted.
module tag_lookup_reader #(
    parameter int WAYS       = 4,
    parameter int SET_BITS   = 4,
    parameter int MAIN_TAG_W = 4,
    parameter int HALT_TAG_W = 20,
    localparam int WAY_W     = $clog2(WAYS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [SET_BITS-1:0]        req_set,
    input  logic [MAIN_TAG_W-1:0]      req_main_tag,
    input  logic [HALT_TAG_W-1:0]      req_halt_tag,
    output logic [SET_BITS-1:0]        rd_set,
    output logic [WAYS-1:0]            rd_way_en,
    input  logic [WAYS-1:0]            valid_in,
    input  logic [WAYS*MAIN_TAG_W-1:0] main_tag_in,
    input  logic [WAYS*HALT_TAG_W-1:0] halt_tag_in,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic                       rsp_hit,
    output logic [WAY_W-1:0]           rsp_way,
    output logic                       rsp_multi
`ifdef TAG_LOOKUP_STATS_EN
    ,
    output logic [15:0]                stat_lookups,
    output logic [15:0]                stat_hits,
    output logic [15:0]                stat_halted
`endif
);

    localparam int CNT_W = $clog2(WAYS + 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_FILTER  = 2'd1;
    localparam logic [1:0] ST_COMPARE = 2'd2;
    localparam logic [1:0] ST_RESP    = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [SET_BITS-1:0]   set_q, set_d;
    logic [MAIN_TAG_W-1:0] main_tag_q, main_tag_d;
    logic [HALT_TAG_W-1:0] halt_tag_q, halt_tag_d;
    logic [WAYS-1:0]       surv_q, surv_d;
    logic                  hit_q, hit_d;
    logic [WAY_W-1:0]      way_q, way_d;
    logic                  multi_q, multi_d;

    logic [WAYS-1:0]       survivors;
    logic [WAYS-1:0]       match;
    logic [WAY_W-1:0]      match_way;
    logic [CNT_W-1:0]      match_cnt;

    // Main-tag pre-compare: only valid ways whose narrow tag matches survive.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch so no latch is inferred.
        survivors = '0;
        for (int w = 0; w < WAYS; w++) begin
            survivors[w] = valid_in[w] &&
                           (main_tag_in[w*MAIN_TAG_W +: MAIN_TAG_W] == main_tag_q);
        end
    end

    // Halt-tag compare, gated by the registered survivor mask so halted ways never count.
    always_comb begin
        match     = '0;
        match_way = '0;
        match_cnt = '0;
        for (int w = 0; w < WAYS; w++) begin
            match[w] = surv_q[w] &&
                       (halt_tag_in[w*HALT_TAG_W +: HALT_TAG_W] == halt_tag_q);
        end
        // Walk downward so the lowest matching index is the one left standing.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (match[w]) match_way = WAY_W'(w);
        end
        for (int w = 0; w < WAYS; w++) begin
            match_cnt = match_cnt + {{(CNT_W-1){1'b0}}, match[w]};
        end
    end

    // Next-state and datapath-load decisions for the lookup FSM.
    always_comb begin
        state_d    = state_q;
        set_d      = set_q;
        main_tag_d = main_tag_q;
        halt_tag_d = halt_tag_q;
        surv_d     = surv_q;
        hit_d      = hit_q;
        way_d      = way_q;
        multi_d    = multi_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    set_d      = req_set;
                    main_tag_d = req_main_tag;
                    halt_tag_d = req_halt_tag;
                    state_d    = ST_FILTER;
                end
            end
            ST_FILTER: begin
                surv_d = survivors;
                if (|survivors) begin
                    state_d = ST_COMPARE;
                end else begin
                    // Every way halted: the answer is a miss without touching halt tags.
                    hit_d   = 1'b0;
                    way_d   = '0;
                    multi_d = 1'b0;
                    state_d = ST_RESP;
                end
            end
            ST_COMPARE: begin
                hit_d   = |match;
                way_d   = match_way;
                multi_d = (match_cnt > CNT_W'(1));
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q    <= ST_IDLE;
            set_q      <= '0;
            main_tag_q <= '0;
            halt_tag_q <= '0;
            surv_q     <= '0;
            hit_q      <= 1'b0;
            way_q      <= '0;
            multi_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            set_q      <= set_d;
            main_tag_q <= main_tag_d;
            halt_tag_q <= halt_tag_d;
            surv_q     <= surv_d;
            hit_q      <= hit_d;
            way_q      <= way_d;
            multi_q    <= multi_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rd_set    = set_q;
    // Halt-tag reads are enabled only for survivors and only in COMPARE.
    assign rd_way_en = (state_q == ST_COMPARE) ? surv_q : '0;
    assign rsp_hit   = hit_q;
    assign rsp_way   = way_q;
    assign rsp_multi = multi_q;

`ifdef TAG_LOOKUP_STATS_EN
    logic [15:0]      lookups_q, hits_q, halted_q;
    logic [CNT_W-1:0] halted_cnt;

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    // Number of valid ways halted by the pre-compare this cycle.
    always_comb begin
        halted_cnt = '0;
        for (int w = 0; w < WAYS; w++) begin
            halted_cnt = halted_cnt + {{(CNT_W-1){1'b0}}, valid_in[w] & ~survivors[w]};
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            lookups_q <= '0;
            hits_q    <= '0;
            halted_q  <= '0;
        end else begin
            if (rsp_valid && rsp_ready) begin
                lookups_q <= sat_add(lookups_q, 16'd1);
                if (hit_q) hits_q <= sat_add(hits_q, 16'd1);
            end
            if (state_q == ST_FILTER) begin
                halted_q <= sat_add(halted_q, 16'(halted_cnt));
            end
        end
    end

    assign stat_lookups = lookups_q;
    assign stat_hits    = hits_q;
    assign stat_halted  = halted_q;
`endif

endmodule

// File: tb/tb_tag_lookup_reader.sv
// Self-checking bench for tag_lookup_reader: directed scenarios followed by
// randomized lookups, all checked against a behavioural tag-store model.
module tb_tag_lookup_reader;

    localparam int WAYS = 4;
    localparam int SB   = 4;
    localparam int MW   = 4;
    localparam int HW   = 20;
    localparam int SETS = 1 << SB;

    logic               clk = 1'b0;
    logic               reset;
    logic               req_valid;
    logic               req_ready;
    logic [SB-1:0]      req_set;
    logic [MW-1:0]      req_main_tag;
    logic [HW-1:0]      req_halt_tag;
    logic [SB-1:0]      rd_set;
    logic [WAYS-1:0]    rd_way_en;
    logic [WAYS-1:0]    valid_in;
    logic [WAYS*MW-1:0] main_tag_in;
    logic [WAYS*HW-1:0] halt_tag_in;
    logic               rsp_valid;
    logic               rsp_ready;
    logic               rsp_hit;
    logic [1:0]         rsp_way;
    logic               rsp_multi;
`ifdef TAG_LOOKUP_STATS_EN
    logic [15:0]        stat_lookups, stat_hits, stat_halted;
    int                 m_lookups, m_hits, m_halted;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Tag store contents, presented combinationally for rd_set.
    logic          mem_valid [SETS][WAYS];
    logic [MW-1:0] mem_main  [SETS][WAYS];
    logic [HW-1:0] mem_halt  [SETS][WAYS];

    tag_lookup_reader #(.WAYS(WAYS), .SET_BITS(SB), .MAIN_TAG_W(MW), .HALT_TAG_W(HW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_set(req_set),
        .req_main_tag(req_main_tag), .req_halt_tag(req_halt_tag),
        .rd_set(rd_set), .rd_way_en(rd_way_en),
        .valid_in(valid_in), .main_tag_in(main_tag_in), .halt_tag_in(halt_tag_in),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
        .rsp_way(rsp_way), .rsp_multi(rsp_multi)
`ifdef TAG_LOOKUP_STATS_EN
        , .stat_lookups(stat_lookups), .stat_hits(stat_hits), .stat_halted(stat_halted)
`endif
    );

    always #5 clk = ~clk;

    always_comb begin
        valid_in    = '0;
        main_tag_in = '0;
        halt_tag_in = '0;
        for (int w = 0; w < WAYS; w++) begin
            valid_in[w]            = mem_valid[rd_set][w];
            main_tag_in[w*MW +: MW] = mem_main[rd_set][w];
            halt_tag_in[w*HW +: HW] = mem_halt[rd_set][w];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_set(input int s);
        for (int w = 0; w < WAYS; w++) begin
            mem_valid[s][w] = 1'b0;
            mem_main[s][w]  = '0;
            mem_halt[s][w]  = '0;
        end
    endtask

    task automatic put(input int s, input int w, input logic v, input logic [MW-1:0] m,
                       input logic [HW-1:0] h);
        mem_valid[s][w] = v;
        mem_main[s][w]  = m;
        mem_halt[s][w]  = h;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
`ifdef TAG_LOOKUP_STATS_EN
        m_lookups = 0;
        m_hits    = 0;
        m_halted  = 0;
`endif
    endtask

    // One complete lookup, with `hold` cycles of response backpressure.
    task automatic lookup(input string name, input int s, input logic [MW-1:0] m,
                          input logic [HW-1:0] h, input int hold);
        logic [WAYS-1:0] exp_surv;
        int              hit_ways[$];
        int              halted;
        logic            exp_hit, exp_multi;
        logic [1:0]      exp_way;
        int              budget;

        exp_surv = '0;
        halted   = 0;
        for (int w = 0; w < WAYS; w++) begin
            if (mem_valid[s][w] && mem_main[s][w] == m) begin
                exp_surv[w] = 1'b1;
                if (mem_halt[s][w] == h) hit_ways.push_back(w);
            end else if (mem_valid[s][w]) begin
                halted++;
            end
        end
        exp_hit   = (hit_ways.size() > 0);
        exp_way   = exp_hit ? 2'(hit_ways[0]) : 2'd0;
        exp_multi = (hit_ways.size() > 1);

        budget = 0;
        while (!req_ready && budget < 10) begin
            step();
            budget++;
        end
        check({name, " ready_before_req"}, 32'(req_ready), 32'd1);

        req_valid    = 1'b1;
        req_set      = SB'(s);
        req_main_tag = m;
        req_halt_tag = h;
        step();
        req_valid = 1'b0;
        // FILTER cycle
        check({name, " filter_req_ready"}, 32'(req_ready), 32'd0);
        check({name, " filter_rd_set"}, 32'(rd_set), 32'(s));
        check({name, " filter_way_en"}, 32'(rd_way_en), 32'd0);
        check({name, " filter_rsp_valid"}, 32'(rsp_valid), 32'd0);
        step();
        if (exp_surv != '0) begin
            // COMPARE cycle
            check({name, " compare_way_en"}, 32'(rd_way_en), 32'(exp_surv));
            check({name, " compare_rsp_valid"}, 32'(rsp_valid), 32'd0);
            step();
        end
        // First RESP cycle
        check({name, " rsp_valid"}, 32'(rsp_valid), 32'd1);
        check({name, " rsp_hit"}, 32'(rsp_hit), 32'(exp_hit));
        check({name, " rsp_way"}, 32'(rsp_way), 32'(exp_way));
        check({name, " rsp_multi"}, 32'(rsp_multi), 32'(exp_multi));
        check({name, " resp_way_en"}, 32'(rd_way_en), 32'd0);
        for (int i = 0; i < hold; i++) begin
            step();
            check({name, " hold_valid"}, 32'(rsp_valid), 32'd1);
            check({name, " hold_ready"}, 32'(req_ready), 32'd0);
            check({name, " hold_fields"}, {29'd0, rsp_hit, rsp_way},
                  {29'd0, exp_hit, exp_way});
            check({name, " hold_multi"}, 32'(rsp_multi), 32'(exp_multi));
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check({name, " idle_after_rsp"}, 32'(req_ready), 32'd1);
        check({name, " rsp_dropped"}, 32'(rsp_valid), 32'd0);
`ifdef TAG_LOOKUP_STATS_EN
        m_lookups++;
        if (exp_hit) m_hits++;
        m_halted += halted;
`endif
    endtask

    initial begin
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_set      = '0;
        req_main_tag = '0;
        req_halt_tag = '0;
        rsp_ready    = 1'b0;
        for (int s = 0; s < SETS; s++) clear_set(s);

        do_reset();
        check("reset req_ready", 32'(req_ready), 32'd1);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset rsp_fields", {29'd0, rsp_hit, rsp_way}, 32'd0);
        check("reset rsp_multi", 32'(rsp_multi), 32'd0);
        check("reset rd_way_en", 32'(rd_way_en), 32'd0);
        check("reset rd_set", 32'(rd_set), 32'd0);

        // Single hit in way 2 of set 3.
        put(3, 0, 1'b1, 4'h1, 20'h12345);
        put(3, 1, 1'b1, 4'h2, 20'h12345);
        put(3, 2, 1'b1, 4'hA, 20'h12345);
        put(3, 3, 1'b1, 4'h3, 20'h12345);
        lookup("single_hit", 3, 4'hA, 20'h12345, 0);

        // All ways halted.
        lookup("all_halted", 3, 4'hB, 20'h12345, 0);

        // Main match, halt miss in ways 0 and 1.
        clear_set(4);
        put(4, 0, 1'b1, 4'h5, 20'h1);
        put(4, 1, 1'b1, 4'h5, 20'h2);
        put(4, 2, 1'b1, 4'h6, 20'h3);
        lookup("halt_miss", 4, 4'h5, 20'h3, 0);

        // Multi-hit on ways 1 and 3, with backpressure.
        clear_set(6);
        put(6, 1, 1'b1, 4'h7, 20'hABCDE);
        put(6, 3, 1'b1, 4'h7, 20'hABCDE);
        lookup("multi_hit", 6, 4'h7, 20'hABCDE, 5);

        // Reset during COMPARE discards the lookup.
        req_valid    = 1'b1;
        req_set      = 4'd6;
        req_main_tag = 4'h7;
        req_halt_tag = 20'hABCDE;
        step();
        req_valid = 1'b0;
        step();
        check("pre_reset compare_way_en", 32'(rd_way_en), 32'b1010);
        reset = 1'b1;
        step();
        reset = 1'b0;
`ifdef TAG_LOOKUP_STATS_EN
        m_lookups = 0;
        m_hits    = 0;
        m_halted  = 0;
`endif
        check("mid_reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_reset req_ready", 32'(req_ready), 32'd1);
        check("mid_reset rd_way_en", 32'(rd_way_en), 32'd0);
        check("mid_reset rd_set", 32'(rd_set), 32'd0);
        check("mid_reset rsp_hit", 32'(rsp_hit), 32'd0);
        step();
        check("post_reset no_rsp", 32'(rsp_valid), 32'd0);

        // Invalid way with matching tags never hits.
        clear_set(7);
        put(7, 0, 1'b0, 4'hC, 20'h55555);
        put(7, 1, 1'b1, 4'h1, 20'h55555);
        put(7, 2, 1'b1, 4'h2, 20'h55555);
        put(7, 3, 1'b1, 4'h3, 20'h55555);
        lookup("invalid_way", 7, 4'hC, 20'h55555, 0);
`ifdef TAG_LOOKUP_STATS_EN
        check("stats lookups_after_invalid", 32'(stat_lookups), 32'd1);
        check("stats hits_after_invalid", 32'(stat_hits), 32'd0);
        check("stats halted_after_invalid", 32'(stat_halted), 32'd3);
`endif

        // Randomized lookups over a small tag alphabet so hits, misses and multi-hits all occur.
        for (int i = 0; i < 60; i++) begin
            int s;
            s = int'($urandom_range(0, SETS - 1));
            for (int w = 0; w < WAYS; w++) begin
                put(s, w, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
                    20'($urandom_range(0, 3)));
            end
            lookup("random", s, 4'($urandom_range(0, 3)), 20'($urandom_range(0, 3)),
                   int'($urandom_range(0, 2)));
        end
`ifdef TAG_LOOKUP_STATS_EN
        check("stats lookups_final", 32'(stat_lookups), 32'(m_lookups));
        check("stats hits_final", 32'(stat_hits), 32'(m_hits));
        check("stats halted_final", 32'(stat_halted), 32'(m_halted));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tag_lookup_reader.md
# tag_lookup_reader

Read-side controller for the way-halting cache tag store. It accepts one lookup request at a time and drives the set index to the per-way main and halt tag arrays. A cheap MAIN_TAG_W-bit main-tag pre-compare halts non-matching ways, so only surviving ways read and compare their HALT_TAG_W-bit halt tag. Hit/miss and hit way are returned over a valid/ready response channel. It sits between the cache controller and the tag arrays' write path, which it never drives.

## Interface
Parameters:
- WAYS, 4, number of ways; power of two, 2..8
- SET_BITS, 4, set index width
- MAIN_TAG_W, 4, main (pre-compare) tag width per way
- HALT_TAG_W, 20, halt (full-compare) tag width per way

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  lookup request present
- req_ready  out  1  controller can accept a request
- req_set  in  SET_BITS  set index
- req_main_tag  in  MAIN_TAG_W  main tag of lookup address
- req_halt_tag  in  HALT_TAG_W  halt tag of lookup address
- rd_set  out  SET_BITS  set index to tag arrays
- rd_way_en  out  WAYS  per-way halt-tag read enable, one bit per way
- valid_in  in  WAYS  per-way valid bits of rd_set
- main_tag_in  in  WAYS*MAIN_TAG_W  main tags of rd_set; way w at [w*MAIN_TAG_W +: MAIN_TAG_W]
- halt_tag_in  in  WAYS*HALT_TAG_W  halt tags of rd_set; same packing
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_hit  out  1  lookup hit
- rsp_way  out  log2(WAYS)  hit way; 0 on miss
- rsp_multi  out  1  more than one way matched (error)

## Operation
- FSM states: IDLE, FILTER, COMPARE, RESP.
- IDLE: req_ready=1. On req_valid, register set and both tags, then go to FILTER. rd_way_en=0.
- FILTER: rd_set = registered set. Compute survivors[w] = valid_in[w] && main_tag_in[w]==reg_main_tag and register them as the halt mask.
  - If any survivor exists, go to COMPARE.
  - Otherwise load a miss (rsp_hit=0, rsp_way=0, rsp_multi=0) and go to RESP, skipping COMPARE.
- COMPARE: rd_way_en = registered survivors and rd_set is held. Compute match[w] = survivors[w] && halt_tag_in[w]==reg_halt_tag.
  - rsp_hit = |match.
  - rsp_way = lowest index set in match.
  - rsp_multi = popcount(match)>1.
  - Register all three, then go to RESP.
- RESP: rsp_valid=1. Response fields are stable until the handshake. On rsp_ready, go to IDLE.
- Halt tags of halted ways are never compared, even if they would match. This is the power-saving contract. rd_way_en must be 0 for halted ways in every cycle.
- Outside COMPARE, rd_way_en is 0. rd_set holds the last registered set.
- Invalid ways are never survivors, regardless of tag contents.

## Timing
- Reset values: req_ready=1 (IDLE), rsp_valid=0, rsp_hit=0, rsp_way=0, rsp_multi=0, rd_way_en=0, rd_set=0, all internal registers 0.
- Accept handshake in cycle T moves the FSM to FILTER in T+1.
- Path with survivors: COMPARE in T+2, rsp_valid=1 in T+3. Latency is 3 cycles.
- All-halted path: rsp_valid=1 in T+2. Latency is 2 cycles.
- If rsp_ready=1 at the first RESP cycle, req_ready returns to 1 in the next cycle. Maximum throughput is one lookup per 4 cycles, or 3 on the all-halted path.
- Backpressure: rsp_ready low holds RESP indefinitely and outputs remain constant. req_ready stays 0 in every non-IDLE state.
- Tag array inputs are sampled combinationally within the state cycle. The arrays must present data for rd_set in the same cycle rd_set is driven.
- Reset asserted in any state: next cycle is IDLE with the reset values, and any in-flight lookup is discarded with no response.

## Configuration
- TAG_LOOKUP_STATS_EN defined adds three 16-bit outputs: stat_lookups, stat_hits, stat_halted.
  - stat_lookups increments on each response handshake.
  - stat_hits increments on each hit response handshake.
  - stat_halted adds the number of halted valid ways on each FILTER cycle.
  - All three saturate at 16'hFFFF and clear on reset.
- TAG_LOOKUP_STATS_EN undefined: these ports and their logic are absent, and all other behaviour is identical.

## Test plan
- Single hit: set 3, way 2 valid with main 4'hA / halt 20'h12345, other ways mismatched on main tag. Request same tags, rsp_ready=1 -> rsp_valid at T+3, rsp_hit=1, rsp_way=2, rsp_multi=0. rd_way_en=4'b0100 only in COMPARE.
- All halted: no valid way with main 4'hA, request main 4'hA -> rsp_valid at T+2, rsp_hit=0, rsp_way=0, rd_way_en never nonzero.
- Main match, halt miss: ways 0 and 1 main 4'h5, halt 20'h1 and 20'h2. Request halt 20'h3 -> rd_way_en=4'b0011 in COMPARE, rsp_hit=0.
- Multi-hit: ways 1 and 3 identical valid tags, request matches -> rsp_hit=1, rsp_way=1, rsp_multi=1.
- Backpressure and reset: hold rsp_ready=0 for 5 cycles -> response stable and req_ready=0 throughout. Assert reset in COMPARE of a following lookup -> next cycle rsp_valid=0, req_ready=1, no response emitted.
- Invalid-way gating: way 0 valid_in=0 with matching tags -> rsp_hit=0. With TAG_LOOKUP_STATS_EN defined, stat_lookups=1 and stat_hits=0.
